// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;

  localparam int PHASE_W = 21;
  localparam int BIT_W   = 4;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data lines plus a registered clock falling-edge strobe.
// The edge strobe rises 3 cycles after the pin falls; no backpressure.
module ps2_line_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clk_line,
  input  logic i_dat_line,
  output logic o_clk_sync,
  output logic o_clk_fe,
  output logic o_dat_sync
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_clk_fe;
  logic r_dat_meta;
  logic r_dat_sync;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_clk_fe   <= 1'b0;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= i_clk_line;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_clk_fe   <= r_clk_prev & ~r_clk_sync;
      r_dat_meta <= i_dat_line;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign o_clk_sync = r_clk_sync;
  assign o_clk_fe   = r_clk_fe;
  assign o_dat_sync = r_dat_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, then device-clocked 11-bit frame with ack.
// One byte per transaction; tx_ready is high only in IDLE, so upstream holds tx_valid until accepted.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clock_i,
  input  logic       ps2_data_i,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam logic [PHASE_W-1:0] LP_INH_LAST  = PHASE_W'(INHIBIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LP_REQ_LAST  = PHASE_W'(REQ_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LP_TO_LAST   = PHASE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LP_PHASE_MAX = '1;

  ps2_tx_state_e      r_state;
  ps2_tx_state_e      w_state_nxt;
  logic [PHASE_W-1:0] r_cnt;
  logic [PHASE_W-1:0] w_cnt_nxt;
  logic [BIT_W-1:0]   r_bit_n;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [7:0]         r_data;
  logic [7:0]         w_data_nxt;
  logic               r_parity;
  logic               w_parity_nxt;
  logic               r_dbit_oe;
  logic               w_dbit_oe_nxt;
  logic               r_ack_ok;
  logic               w_ack_ok_nxt;
  logic               r_timeout;
  logic               w_timeout_nxt;
  logic               w_clk_sync;
  logic               w_clk_fe;
  logic               w_dat_sync;
  logic               w_timed_out;

  ps2_line_sync u_line_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clk_line (ps2_clock_i),
    .i_dat_line (ps2_data_i),
    .o_clk_sync (w_clk_sync),
    .o_clk_fe   (w_clk_fe),
    .o_dat_sync (w_dat_sync)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_n   <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_dbit_oe <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_n   <= w_bit_nxt;
      r_data    <= w_data_nxt;
      r_parity  <= w_parity_nxt;
      r_dbit_oe <= w_dbit_oe_nxt;
      r_ack_ok  <= w_ack_ok_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign w_timed_out = (r_cnt >= LP_TO_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = (r_cnt == LP_PHASE_MAX) ? r_cnt : r_cnt + 1'b1;
    w_bit_nxt     = r_bit_n;
    w_data_nxt    = r_data;
    w_parity_nxt  = r_parity;
    w_dbit_oe_nxt = r_dbit_oe;
    w_ack_ok_nxt  = r_ack_ok;
    w_timeout_nxt = r_timeout;
    ps2_clock_oe  = 1'b0;
    ps2_data_oe   = 1'b0;
    done          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (tx_valid) begin
          w_state_nxt   = ST_INHIBIT;
          w_data_nxt    = tx_data;
          w_parity_nxt  = odd_parity(tx_data);
          w_ack_ok_nxt  = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end
      ST_INHIBIT: begin
        ps2_clock_oe = 1'b1;
        if (r_cnt == LP_INH_LAST) begin
          w_state_nxt = ST_REQ;
          w_cnt_nxt   = '0;
        end
      end
      ST_REQ: begin
        ps2_clock_oe = 1'b1;
        ps2_data_oe  = 1'b1;
        if (r_cnt == LP_REQ_LAST) begin
          w_state_nxt   = ST_SEND;
          w_cnt_nxt     = '0;
          w_bit_nxt     = '0;
          w_dbit_oe_nxt = 1'b1;
        end
      end
      ST_SEND: begin
        ps2_data_oe = r_dbit_oe;
        // r_bit_n counts edges already seen, so it indexes the bit due after this edge.
        if (w_clk_fe) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit_n + 1'b1;
          if (r_bit_n < 4'd8) begin
            w_dbit_oe_nxt = ~r_data[r_bit_n[2:0]];
          end else if (r_bit_n == 4'd8) begin
            w_dbit_oe_nxt = ~r_parity;
          end else begin
            w_dbit_oe_nxt = 1'b0;
            w_state_nxt   = ST_ACK;
          end
        end else if (w_timed_out) begin
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
          w_ack_ok_nxt  = 1'b0;
        end
      end
      ST_ACK: begin
        if (w_clk_fe) begin
          w_cnt_nxt    = '0;
          w_ack_ok_nxt = ~w_dat_sync;
          w_state_nxt  = ST_WAIT_IDLE;
        end else if (w_timed_out) begin
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
          w_ack_ok_nxt  = 1'b0;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_sync && w_dat_sync) begin
          w_state_nxt = ST_DONE;
        end else if (w_clk_fe) begin
          w_cnt_nxt = '0;
        end else if (w_timed_out) begin
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
          w_ack_ok_nxt  = 1'b0;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign tx_ready   = (r_state == ST_IDLE);
  assign rx_inhibit = (r_state != ST_IDLE);
  assign ack_ok     = r_ack_ok;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames, a negedge monitor scores each done pulse
// against expectations queued by the stimulus thread.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 120;
  localparam int REQ  = 20;
  localparam int TO   = 1000;
  localparam int HALF = 50;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clock_i;
  logic       ps2_data_i;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       rx_inhibit;
  logic       done;
  logic       ack_ok;
  logic       timeout;

  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       glitch = 1'b0;
  int         dev_nclk = 11;
  logic       dev_ack_en = 1'b1;
  int         dev_falls = 0;
  logic [9:0] cap = '0;

  // Open-drain lines with pull-ups; glitch forces the clock line high to fake device edges.
  assign ps2_clock_i = glitch | (~ps2_clock_oe & dev_clk);
  assign ps2_data_i  = ~ps2_data_oe & dev_dat;

  always #5 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .ps2_clock_i  (ps2_clock_i),
    .ps2_data_i   (ps2_data_i),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .rx_inhibit   (rx_inhibit),
    .done         (done),
    .ack_ok       (ack_ok),
    .timeout      (timeout)
  );

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       chk_bits;
    logic       exp_ack;
    logic       exp_to;
    int         send_len;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Device model: once the host releases clock after the request, generate dev_nclk clock pulses.
  initial begin
    int nc;
    forever begin
      @(negedge clock);
      if (ps2_clock_oe && ps2_data_oe) begin
        nc = dev_nclk;
        while (ps2_clock_oe) @(negedge clock);
        dev_falls = 0;
        for (int k = 1; k <= nc; k++) begin
          if (k == 11 && dev_ack_en) dev_dat = 1'b0;
          repeat (HALF) @(negedge clock);
          dev_clk = 1'b0;
          dev_falls++;
          repeat (HALF) @(negedge clock);
          if (k <= 10) cap[k-1] = ps2_data_i;
          dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
      end
    end
  end

  // Monitor: phase run lengths, busy-ready violations, and scoring at each done pulse.
  initial begin
    int   inh_run, inh_len, req_run, req_len, send_run, send_len, busy_ready;
    logic post;
    exp_t e;
    inh_run = 0; inh_len = 0; req_run = 0; req_len = 0;
    send_run = 0; send_len = 0; busy_ready = 0; post = 1'b0;
    forever begin
      @(negedge clock);
      if (post) begin
        chk("tx_ready_after_done", tx_ready, 1);
        chk("rx_inhibit_after_done", rx_inhibit, 0);
        post = 1'b0;
      end
      if (ps2_clock_oe && !ps2_data_oe) inh_run++;
      else if (inh_run != 0) begin inh_len = inh_run; inh_run = 0; end
      if (ps2_clock_oe && ps2_data_oe) req_run++;
      else if (req_run != 0) begin req_len = req_run; req_run = 0; end
      if (!ps2_clock_oe && ps2_data_oe) send_run++;
      else if (send_run != 0) begin send_len = send_run; send_run = 0; end
      if ((ps2_clock_oe || ps2_data_oe) && tx_ready) busy_ready++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_without_frame", done, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_ok", ack_ok, e.exp_ack);
          chk("timeout", timeout, e.exp_to);
          chk("rx_inhibit_at_done", rx_inhibit, 1);
          chk("oe_released_at_done", {ps2_clock_oe, ps2_data_oe}, 0);
          chk("inhibit_cycles", inh_len, INH);
          chk("req_cycles", req_len, REQ);
          chk("tx_ready_while_busy", busy_ready, 0);
          if (e.chk_bits) chk("line_bits", cap, {1'b1, e.par, e.d});
          if (e.send_len != 0) chk("send_to_timeout_cycles", send_len, e.send_len);
          post = 1'b1;
        end
        busy_ready = 0;
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!tx_ready && n < 20000) begin @(negedge clock); n++; end
    if (!tx_ready) chk("accept_bound", tx_ready, 1);
    @(negedge clock);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin @(negedge clock); n++; end
    if (!done) chk("done_bound", done, 1);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic cb,
                          input logic ea, input logic et, input int sl);
    exp_t e;
    e.d = d; e.par = p; e.chk_bits = cb; e.exp_ack = ea; e.exp_to = et; e.send_len = sl;
    sb.push_back(e);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic p, input int nclk, input logic dack,
                           input logic ea, input logic et, input int sl, input logic cb);
    push_exp(d, p, cb, ea, et, sl);
    dev_nclk = nclk;
    dev_ack_en = dack;
    @(negedge clock);
    tx_data = d;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    chk("rst_clock_oe", ps2_clock_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_inhibit", rx_inhibit, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_ok", ack_ok, 0);
    chk("rst_timeout", timeout, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // 0xED with 0xFF held behind it: second byte only accepted after done.
    dev_nclk = 11;
    dev_ack_en = 1'b1;
    push_exp(PS2_CMD_SET_LED, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    tx_data = PS2_CMD_SET_LED;
    tx_valid = 1'b1;
    wait_accept();
    tx_data = PS2_CMD_RESET;
    push_exp(PS2_CMD_RESET, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    wait_done();
    repeat (2) @(negedge clock);
    chk("held_byte_accepted", tx_ready, 0);
    chk("held_byte_rx_inhibit", rx_inhibit, 1);
    tx_valid = 1'b0;
    wait_done();

    // 0x00, device does not ack.
    run_frame(8'h00, 1'b1, 11, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    // 0x55, silent device: timeout after exactly TO cycles in SEND.
    run_frame(8'h55, 1'b1, 0, 1'b0, 1'b0, 1'b1, TO, 1'b0);

    // Abort with reset after the fourth falling edge of a 0x00 frame.
    dev_nclk = 4;
    dev_ack_en = 1'b0;
    dev_falls = 0;
    @(negedge clock);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    n = 0;
    while (dev_falls < 4 && n < 5000) begin @(negedge clock); n++; end
    chk("abort_reached_fe4", dev_falls, 4);
    repeat (10) @(negedge clock);
    chk("abort_data_oe_before_reset", ps2_data_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_clock_oe", ps2_clock_oe, 0);
    chk("abort_data_oe", ps2_data_oe, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_tx_ready", tx_ready, 1);
    chk("abort_rx_inhibit", rx_inhibit, 0);
    repeat (100) @(negedge clock);

    // 0xF4 acked after the abort.
    run_frame(8'hF4, 1'b0, 11, 1'b1, 1'b1, 1'b0, 0, 1'b1);

    // 0x07 with spurious clock edges injected in INHIBIT and REQ.
    push_exp(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    dev_nclk = 11;
    dev_ack_en = 1'b1;
    @(negedge clock);
    tx_data = 8'h07;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    repeat (30) @(negedge clock);
    glitch = 1'b1;
    repeat (6) @(negedge clock);
    glitch = 1'b0;
    n = 0;
    while (!ps2_data_oe && n < 1000) begin @(negedge clock); n++; end
    chk("reached_req", ps2_data_oe, 1);
    repeat (3) @(negedge clock);
    glitch = 1'b1;
    repeat (6) @(negedge clock);
    glitch = 1'b0;
    wait_done();

    repeat (20) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
